// File: rtl/mem_interface_unit_if.sv
// Bus bundle between the instruction unit, mem_interface_unit and byte-wide memory.
// The err signal exists only when MIU_TIMEOUT_EN is defined.
interface mem_interface_unit_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
);
  logic                  load;
  logic                  store;
  logic [ADDR_W-1:0]     addr;
  logic [2*DATA_W-1:0]   result;
  logic [DATA_W-1:0]     data;
  logic                  mem_done;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_resp;
`ifdef MIU_TIMEOUT_EN
  logic                  err;
`endif

  // View of the memory interface unit itself
  modport slave (
    input  load, store, addr, result, mem_rdata, mem_resp,
    output data, mem_done, mem_req, mem_we, mem_addr, mem_wdata
`ifdef MIU_TIMEOUT_EN
    , output err
`endif
  );

  // View of the environment: instruction unit plus memory
  modport master (
    output load, store, addr, result, mem_rdata, mem_resp,
    input  data, mem_done, mem_req, mem_we, mem_addr, mem_wdata
`ifdef MIU_TIMEOUT_EN
    , input err
`endif
  );
endinterface

// File: rtl/mem_interface_unit.sv
// Converts level-held load/store requests into byte-wide req/resp memory transactions.
// Optional response timeout with sticky err flag is enabled by defining MIU_TIMEOUT_EN.
module mem_interface_unit #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
`ifdef MIU_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_interface_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_ST_LO,
    S_ST_HI,
    S_DONE,
    S_REARM
  } state_t;

  state_t                r_state, w_state;
  logic                  r_armed, w_armed;
  logic [ADDR_W-1:0]     r_addr, w_addr;
  logic [2*DATA_W-1:0]   r_result, w_result;
  logic [DATA_W-1:0]     r_data, w_data;
  logic                  r_mem_done, w_mem_done;
  logic                  r_mem_req, w_mem_req;
  logic                  r_mem_we, w_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata, w_mem_wdata;
  logic                  w_req_any;
  logic                  w_phase_start;
  logic                  w_abort;
  logic                  w_tmo_hit;

  assign w_req_any = bus.load | bus.store;

`ifdef MIU_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt;
  logic             r_err, w_err;

  // Counts cycles of the current mem_req phase; restarts at every phase start
  always_comb begin
    w_tmo_cnt = r_tmo_cnt;
    if (w_phase_start) begin
      w_tmo_cnt = '0;
    end else if (r_mem_req) begin
      w_tmo_cnt = r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_tmo_hit = r_mem_req && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Next-state and registered-output computation
  always_comb begin
    w_state       = r_state;
    w_armed       = r_armed;
    w_addr        = r_addr;
    w_result      = r_result;
    w_data        = r_data;
    w_mem_done    = 1'b0;
    w_mem_req     = r_mem_req;
    w_mem_we      = r_mem_we;
    w_mem_addr    = r_mem_addr;
    w_mem_wdata   = r_mem_wdata;
    w_phase_start = 1'b0;
    w_abort       = 1'b0;
`ifdef MIU_TIMEOUT_EN
    w_err         = r_err;
`endif

    case (r_state)
      S_IDLE: begin
        if (!w_req_any) begin
          w_armed = 1'b1;
        end else if (r_armed) begin
          w_armed       = 1'b0;
          w_addr        = bus.addr;
          w_result      = bus.result;
          w_mem_req     = 1'b1;
          w_mem_addr    = bus.addr;
          w_phase_start = 1'b1;
`ifdef MIU_TIMEOUT_EN
          w_err         = 1'b0;
`endif
          // load has priority when both requests are raised together
          if (bus.load) begin
            w_state  = S_LD;
            w_mem_we = 1'b0;
          end else begin
            w_state     = S_ST_LO;
            w_mem_we    = 1'b1;
            w_mem_wdata = bus.result[DATA_W-1:0];
          end
        end
      end
      S_LD: begin
        if (bus.mem_resp) begin
          w_data     = bus.mem_rdata;
          w_mem_req  = 1'b0;
          w_mem_done = 1'b1;
          w_state    = S_DONE;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
        end
      end
      S_ST_LO: begin
        if (bus.mem_resp) begin
          w_mem_addr    = r_addr + ADDR_W'(1);
          w_mem_wdata   = r_result[2*DATA_W-1:DATA_W];
          w_phase_start = 1'b1;
          w_state       = S_ST_HI;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
        end
      end
      S_ST_HI: begin
        if (bus.mem_resp) begin
          w_mem_req  = 1'b0;
          w_mem_done = 1'b1;
          w_state    = S_DONE;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
        end
      end
      S_DONE: begin
        w_state = S_REARM;
      end
      S_REARM: begin
        if (!w_req_any) begin
          w_armed = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Timeout abort: end the transaction early, a load returns all-ones
    if (w_abort) begin
      w_mem_req  = 1'b0;
      w_mem_done = 1'b1;
      w_state    = S_DONE;
      if (r_state == S_LD) begin
        w_data = '1;
      end
`ifdef MIU_TIMEOUT_EN
      w_err = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_addr      <= '0;
      r_result    <= '0;
      r_data      <= '0;
      r_mem_done  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state;
      r_armed     <= w_armed;
      r_addr      <= w_addr;
      r_result    <= w_result;
      r_data      <= w_data;
      r_mem_done  <= w_mem_done;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

`ifdef MIU_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt;
      r_err     <= w_err;
    end
  end

  assign bus.err = r_err;
`endif

  assign bus.data      = r_data;
  assign bus.mem_done  = r_mem_done;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed, table-driven bench for mem_interface_unit; the bench acts as instruction unit and memory.
// Timeout checks are compiled in when MIU_TIMEOUT_EN is defined.
module tb_mem_interface_unit;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  mem_interface_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  mem_interface_unit #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef MIU_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic [13:0] addr;
    logic [15:0] res;
    logic [7:0]  rdata;
    int          waits;
    logic        we;
    logic [13:0] a_hi;
    logic [7:0]  d_lo;
    logic [7:0]  d_hi;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(bus_if.mem_req),   32'h0);
    chk({tag, "_we"},    32'(bus_if.mem_we),    32'h0);
    chk({tag, "_addr"},  32'(bus_if.mem_addr),  32'h0);
    chk({tag, "_wdata"}, 32'(bus_if.mem_wdata), 32'h0);
    chk({tag, "_data"},  32'(bus_if.data),      32'h0);
    chk({tag, "_done"},  32'(bus_if.mem_done),  32'h0);
`ifdef MIU_TIMEOUT_EN
    chk({tag, "_err"},   32'(bus_if.err),       32'h0);
`endif
  endtask

  // One full transaction: request, memory responses after v.waits stall cycles per byte, rearm
  task automatic run_vec(input vec_t v, input int idx);
    int          nph;
    logic [13:0] ph_addr;
    string       t;
    t = $sformatf("v%0d", idx);
    bus_if.load   = v.ld;
    bus_if.store  = v.st;
    bus_if.addr   = v.addr;
    bus_if.result = v.res;
    step();
    chk({t, "_acc_req"},  32'(bus_if.mem_req),  32'h1);
    chk({t, "_acc_we"},   32'(bus_if.mem_we),   32'(v.we));
    chk({t, "_acc_addr"}, 32'(bus_if.mem_addr), 32'(v.addr));
    if (v.we) chk({t, "_acc_wdata"}, 32'(bus_if.mem_wdata), 32'(v.d_lo));
    bus_if.addr   = ~v.addr;
    bus_if.result = ~v.res;
    nph     = v.we ? 2 : 1;
    ph_addr = v.addr;
    for (int ph = 0; ph < nph; ph++) begin
      for (int w = 0; w < v.waits; w++) begin
        step();
        chk({t, "_wait_req"},  32'(bus_if.mem_req),  32'h1);
        chk({t, "_wait_addr"}, 32'(bus_if.mem_addr), 32'(ph_addr));
        chk({t, "_wait_done"}, 32'(bus_if.mem_done), 32'h0);
      end
      bus_if.mem_resp  = 1'b1;
      bus_if.mem_rdata = v.rdata;
      step();
      bus_if.mem_resp  = 1'b0;
      bus_if.mem_rdata = ~v.rdata;
      if (ph == nph - 1) begin
        chk({t, "_end_req"},  32'(bus_if.mem_req),  32'h0);
        chk({t, "_end_done"}, 32'(bus_if.mem_done), 32'h1);
        chk({t, "_end_data"}, 32'(bus_if.data),     32'(v.exp_data));
      end else begin
        ph_addr = v.a_hi;
        chk({t, "_hi_req"},   32'(bus_if.mem_req),   32'h1);
        chk({t, "_hi_we"},    32'(bus_if.mem_we),    32'h1);
        chk({t, "_hi_addr"},  32'(bus_if.mem_addr),  32'(v.a_hi));
        chk({t, "_hi_wdata"}, 32'(bus_if.mem_wdata), 32'(v.d_hi));
        chk({t, "_hi_done"},  32'(bus_if.mem_done),  32'h0);
      end
    end
    step();
    chk({t, "_done_pulse"}, 32'(bus_if.mem_done), 32'h0);
    bus_if.load  = 1'b0;
    bus_if.store = 1'b0;
    step();
    chk({t, "_idle_req"}, 32'(bus_if.mem_req), 32'h0);
  endtask

  initial begin
    //         ld    st    addr      res        rdata  w  we    a_hi      d_lo   d_hi   data
    vecs[0] = '{1'b1, 1'b0, 14'h0010, 16'h0000, 8'hA5, 0, 1'b0, 14'h0000, 8'h00, 8'h00, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 14'h0012, 16'hBEEF, 8'h00, 3, 1'b1, 14'h0013, 8'hEF, 8'hBE, 8'hA5};
    vecs[2] = '{1'b0, 1'b1, 14'h3FFF, 16'h1234, 8'h00, 0, 1'b1, 14'h0000, 8'h34, 8'h12, 8'hA5};
    vecs[3] = '{1'b1, 1'b1, 14'h0100, 16'hFFFF, 8'h5A, 1, 1'b0, 14'h0000, 8'h00, 8'h00, 8'h5A};
    vecs[4] = '{1'b1, 1'b0, 14'h3FFF, 16'h0000, 8'h3C, 2, 1'b0, 14'h0000, 8'h00, 8'h00, 8'h3C};
    vecs[5] = '{1'b0, 1'b1, 14'h0000, 16'h00FF, 8'h00, 1, 1'b1, 14'h0001, 8'hFF, 8'h00, 8'h3C};

    reset_n          = 1'b0;
    bus_if.load      = 1'b0;
    bus_if.store     = 1'b0;
    bus_if.addr      = '0;
    bus_if.result    = '0;
    bus_if.mem_rdata = '0;
    bus_if.mem_resp  = 1'b0;
    step();
    step();
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Rearm: a held load must not start a second transaction
    bus_if.load = 1'b1;
    bus_if.addr = 14'h0020;
    step();
    chk("rearm_acc_req", 32'(bus_if.mem_req), 32'h1);
    bus_if.mem_resp  = 1'b1;
    bus_if.mem_rdata = 8'h77;
    step();
    bus_if.mem_resp  = 1'b0;
    chk("rearm_done1", 32'(bus_if.mem_done), 32'h1);
    chk("rearm_data1", 32'(bus_if.data), 32'h77);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rearm_hold_req",  32'(bus_if.mem_req),  32'h0);
      chk("rearm_hold_done", 32'(bus_if.mem_done), 32'h0);
    end
    bus_if.load = 1'b0;
    step();
    bus_if.load = 1'b1;
    bus_if.addr = 14'h0021;
    step();
    chk("rearm_new_req",  32'(bus_if.mem_req),  32'h1);
    chk("rearm_new_addr", 32'(bus_if.mem_addr), 32'h0021);
    bus_if.mem_resp  = 1'b1;
    bus_if.mem_rdata = 8'h11;
    step();
    bus_if.mem_resp  = 1'b0;
    chk("rearm_done2", 32'(bus_if.mem_done), 32'h1);
    chk("rearm_data2", 32'(bus_if.data), 32'h11);
    step();
    bus_if.load = 1'b0;
    step();

    // Stray mem_resp while idle is ignored
    bus_if.mem_resp  = 1'b1;
    bus_if.mem_rdata = 8'hEE;
    step();
    bus_if.mem_resp  = 1'b0;
    chk("stray_req",  32'(bus_if.mem_req),  32'h0);
    chk("stray_done", 32'(bus_if.mem_done), 32'h0);
    chk("stray_data", 32'(bus_if.data),     32'h11);
    step();

    // Reset while the high byte of a store is outstanding
    bus_if.store  = 1'b1;
    bus_if.addr   = 14'h0050;
    bus_if.result = 16'hCAFE;
    step();
    chk("mid_lo_wdata", 32'(bus_if.mem_wdata), 32'hFE);
    bus_if.mem_resp = 1'b1;
    step();
    bus_if.mem_resp = 1'b0;
    chk("mid_hi_addr",  32'(bus_if.mem_addr),  32'h0051);
    chk("mid_hi_wdata", 32'(bus_if.mem_wdata), 32'hCA);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    step();
    chk("mid_rst_nodone", 32'(bus_if.mem_done), 32'h0);
    reset_n = 1'b1;
    step();
    chk("unarmed_req", 32'(bus_if.mem_req), 32'h0);
    bus_if.store = 1'b0;
    step();
    run_vec(vecs[0], 10);

`ifdef MIU_TIMEOUT_EN
    // Load timeout: mem_req held 4 cycles, then abort with err and all-ones data
    bus_if.load = 1'b1;
    bus_if.addr = 14'h0030;
    step();
    chk("tmo_ld_req", 32'(bus_if.mem_req), 32'h1);
    chk("tmo_ld_err0", 32'(bus_if.err), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tmo_ld_hold", 32'(bus_if.mem_req), 32'h1);
    end
    step();
    chk("tmo_ld_req_drop", 32'(bus_if.mem_req),  32'h0);
    chk("tmo_ld_done",     32'(bus_if.mem_done), 32'h1);
    chk("tmo_ld_err",      32'(bus_if.err),      32'h1);
    chk("tmo_ld_data",     32'(bus_if.data),     32'hFF);
    step();
    chk("tmo_ld_pulse", 32'(bus_if.mem_done), 32'h0);
    bus_if.load = 1'b0;
    step();
    chk("tmo_err_sticky", 32'(bus_if.err), 32'h1);

    // Store timeout in the low byte skips the high byte
    bus_if.store  = 1'b1;
    bus_if.addr   = 14'h0040;
    bus_if.result = 16'h9988;
    step();
    chk("tmo_st_err_clr", 32'(bus_if.err), 32'h0);
    for (int i = 0; i < 3; i++) step();
    step();
    chk("tmo_st_req_drop", 32'(bus_if.mem_req),  32'h0);
    chk("tmo_st_done",     32'(bus_if.mem_done), 32'h1);
    chk("tmo_st_err",      32'(bus_if.err),      32'h1);
    bus_if.store = 1'b0;
    step();
    step();
    chk("tmo_st_no_hi", 32'(bus_if.mem_req), 32'h0);

    // Next accepted request clears err
    bus_if.load = 1'b1;
    bus_if.addr = 14'h0031;
    step();
    chk("tmo_clr_err", 32'(bus_if.err), 32'h0);
    bus_if.mem_resp  = 1'b1;
    bus_if.mem_rdata = 8'h42;
    step();
    bus_if.mem_resp = 1'b0;
    chk("tmo_clr_data", 32'(bus_if.data), 32'h42);
    step();
    bus_if.load = 1'b0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
